// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam int FETCH_XLEN  = 32;
    localparam int INSTR_BYTES = 4;
    // Canonical RISC-V nop; out_valid alone marks a bubble, so this value is never driven as one.
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bus: redirect input, sync-read imem port and the decode handshake.
interface fetch_queue_unit_if #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 9
);
    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;
    logic               mem_req;
    logic [IMEM_AW-1:0] mem_addr;
    logic [XLEN-1:0]    mem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [XLEN-1:0]    out_instr;

    modport master (
        input  redirect, redirect_pc, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect, redirect_pc, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push && !flush;
        do_pop   = pop && !flush && (count_q != '0);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: issues imem reads under a queue credit limit, queues responses for decode.
// Define FETCHQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              IMEM_AW  = 9,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               reset,
    fetch_queue_unit_if.master bus
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;

    logic [XLEN-1:0] issue_pc;
    logic            issue, kill, resp_valid;
    logic [CW:0]     occupancy;
    logic            q_push, q_pop, q_empty;
    logic [CW-1:0]   q_count;
    entry_t          q_head, resp_entry, out_entry;
    logic            out_valid;

    // Request side: a pop this cycle does not free a credit, so the next push can never overflow.
    always_comb begin
        kill       = reset || bus.redirect;
        resp_valid = inflight_q && !kill;
        occupancy  = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
        issue      = !reset && (bus.redirect || (occupancy < DEPTH_W));
        issue_pc   = bus.redirect ? (bus.redirect_pc & ~XLEN'(3)) : fetch_pc_q;

        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (issue) begin
            req_pc_d   = issue_pc;
            inflight_d = 1'b1;
            fetch_pc_d = issue_pc + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign resp_entry = {req_pc_q, bus.mem_rdata};
    assign q_empty    = (q_count == '0);

`ifdef FETCHQ_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass    = q_empty && resp_valid;
        out_valid = !q_empty || resp_valid;
        out_entry = !q_empty ? q_head : (resp_valid ? resp_entry : '0);
        q_push    = resp_valid && !(bypass && bus.out_ready);
    end
`else
    always_comb begin
        out_valid = !q_empty;
        out_entry = q_empty ? '0 : q_head;
        q_push    = resp_valid;
    end
`endif

    assign q_pop = out_valid && bus.out_ready && !q_empty;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect),
        .push  (q_push),
        .pop   (q_pop),
        .din   (resp_entry),
        .head  (q_head),
        .count (q_count)
    );

    assign bus.mem_req   = issue;
    assign bus.mem_addr  = issue_pc[IMEM_AW+1:2];
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_entry.pc;
    assign bus.out_instr = out_entry.instr;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: three instances (RESET_PC 0, 0x100, 0xFFFF_FFFC).
module tb_fetch_queue_unit;
    import fetch_pkg::*;

`ifdef FETCHQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;

    fetch_queue_unit_if #(.XLEN(32), .IMEM_AW(9)) bus0 ();
    fetch_queue_unit_if #(.XLEN(32), .IMEM_AW(9)) bus1 ();
    fetch_queue_unit_if #(.XLEN(32), .IMEM_AW(9)) bus2 ();

    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .IMEM_AW(9), .RESET_PC(32'h0000_0000))
        u_dut0 (.clk(clk), .reset(rst0), .bus(bus0));
    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .IMEM_AW(9), .RESET_PC(32'h0000_0100))
        u_dut1 (.clk(clk), .reset(rst1), .bus(bus1));
    fetch_queue_unit #(.XLEN(32), .DEPTH(4), .IMEM_AW(9), .RESET_PC(32'hFFFF_FFFC))
        u_dut2 (.clk(clk), .reset(rst2), .bus(bus2));

    int n_vec = 0;
    int n_err = 0;
    int pops [3] = '{0, 0, 0};
    fetch_entry_t exp0 [$];
    fetch_entry_t exp1 [$];
    fetch_entry_t exp2 [$];

    // imem[i] = i, one-cycle synchronous read
    always @(posedge clk) begin
        if (bus0.mem_req) bus0.mem_rdata <= {23'd0, bus0.mem_addr};
        if (bus1.mem_req) bus1.mem_rdata <= {23'd0, bus1.mem_addr};
        if (bus2.mem_req) bus2.mem_rdata <= {23'd0, bus2.mem_addr};
    end

    function automatic logic [31:0] imem_word(input logic [31:0] pc);
        return {23'd0, pc[10:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_exp(input int idx);
        case (idx)
            0:       exp0.delete();
            1:       exp1.delete();
            default: exp2.delete();
        endcase
    endtask

    task automatic push_stream(input int idx, input logic [31:0] start, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = imem_word(e.pc);
            case (idx)
                0:       exp0.push_back(e);
                1:       exp1.push_back(e);
                default: exp2.push_back(e);
            endcase
        end
    endtask

    task automatic mon(input int idx, input logic fire, input logic [31:0] pc, input logic [31:0] instr);
        fetch_entry_t e;
        bit have;
        if (!fire) return;
        pops[idx]++;
        have = 1'b0;
        case (idx)
            0:       if (exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
            1:       if (exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
            default: if (exp2.size() > 0) begin e = exp2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL dut%0d_unexpected_pop: got pc %h, expected no delivery", idx, pc);
        end else begin
            check($sformatf("dut%0d_out_pc", idx), pc, e.pc);
            check($sformatf("dut%0d_out_instr", idx), instr, e.instr);
        end
    endtask

    // Monitor: every accepted handoff is checked against the expected stream.
    always @(negedge clk) begin
        mon(0, bus0.out_valid && bus0.out_ready && !rst0, bus0.out_pc, bus0.out_instr);
        mon(1, bus1.out_valid && bus1.out_ready && !rst1, bus1.out_pc, bus1.out_instr);
        mon(2, bus2.out_valid && bus2.out_ready && !rst2, bus2.out_pc, bus2.out_instr);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        bus0.out_ready = 1'b0;
        bus0.redirect  = 1'b0;
        clear_exp(0);
        next();
        rst0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int base;
        int nreq;
        bus0.redirect = 1'b0; bus0.redirect_pc = '0; bus0.out_ready = 1'b0;
        bus1.redirect = 1'b0; bus1.redirect_pc = '0; bus1.out_ready = 1'b0;
        bus2.redirect = 1'b0; bus2.redirect_pc = '0; bus2.out_ready = 1'b0;

        // Reset state, then sequential streaming with out_ready held high
        repeat (2) next();
        @(negedge clk);
        check("rst_mem_req",   bus0.mem_req,   1'b0);
        check("rst_out_valid", bus0.out_valid, 1'b0);
        check("rst_out_pc",    bus0.out_pc,    32'h0);
        check("rst_out_instr", bus0.out_instr, 32'h0);
        next();
        rst0 = 1'b0;
        bus0.out_ready = 1'b1;
        push_stream(0, 32'h0, 40);
        base = pops[0];
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("t1_mem_req",   bus0.mem_req,   1'b1);
            check("t1_mem_addr",  bus0.mem_addr,  32'(c));
            check("t1_out_valid", bus0.out_valid, 32'(c >= LAT));
            next();
        end
        check("t1_pop_count", pops[0] - base, 12 - LAT);

        // Back-pressure: queue fills to DEPTH, requests stop, nothing lost on release
        reset0();
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus0.mem_req) nreq++;
            if (c >= 5) check("t2_mem_req_held", bus0.mem_req, 1'b0);
            if (c >= LAT) begin
                check("t2_out_valid_held", bus0.out_valid, 1'b1);
                check("t2_out_pc_stable",  bus0.out_pc,    32'h0);
            end
            next();
        end
        check("t2_req_count", nreq, 4);
        push_stream(0, 32'h0, 40);
        base = pops[0];
        bus0.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            next();
        end
        check("t2_release_pops", pops[0] - base, 12);
        bus0.out_ready = 1'b0;

        // Redirect with three queued entries and one in flight
        reset0();
        repeat (4) next();
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h40;
        clear_exp(0);
        push_stream(0, 32'h40, 40);
        @(negedge clk);
        check("t3_redir_mem_req",  bus0.mem_req,   1'b1);
        check("t3_redir_mem_addr", bus0.mem_addr,  32'h10);
        check("t3_redir_out_valid", bus0.out_valid, 1'b1);
        next();
        bus0.redirect  = 1'b0;
        bus0.out_ready = 1'b1;
        base = pops[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check("t3_first_valid", bus0.out_valid, 32'(LAT == 1));
            next();
        end
        check("t3_pop_count", pops[0] - base, 11 - LAT);

        // Misaligned target, then back-to-back redirects: only the last stream survives
        reset0();
        bus0.out_ready = 1'b1;
        push_stream(0, 32'h0, 40);
        repeat (5) next();
        bus0.out_ready   = 1'b0;
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h43;
        clear_exp(0);
        push_stream(0, 32'h40, 40);
        @(negedge clk);
        check("t4_misalign_addr", bus0.mem_addr, 32'h10);
        next();
        bus0.redirect  = 1'b0;
        bus0.out_ready = 1'b1;
        base = pops[0];
        repeat (6) begin
            @(negedge clk);
            next();
        end
        check("t4_misalign_pops", pops[0] - base, 7 - LAT);
        bus0.out_ready   = 1'b0;
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h80;
        clear_exp(0);
        @(negedge clk);
        check("t4_redir1_addr", bus0.mem_addr, 32'h20);
        next();
        bus0.redirect_pc = 32'h100;
        push_stream(0, 32'h100, 40);
        @(negedge clk);
        check("t4_redir2_addr", bus0.mem_addr, 32'h40);
        next();
        bus0.redirect  = 1'b0;
        bus0.out_ready = 1'b1;
        base = pops[0];
        repeat (8) begin
            @(negedge clk);
            next();
        end
        check("t4_redir2_pops", pops[0] - base, 9 - LAT);
        bus0.out_ready = 1'b0;

        // Reset mid-stream with a full queue, restart from RESET_PC = 0x100
        rst1 = 1'b0;
        repeat (6) next();
        @(negedge clk);
        check("t5_pre_out_valid", bus1.out_valid, 1'b1);
        next();
        rst1 = 1'b1;
        next();
        rst1 = 1'b0;
        push_stream(1, 32'h100, 40);
        bus1.out_ready = 1'b1;
        base = pops[1];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("t5_post_out_valid", bus1.out_valid, 1'b0);
                check("t5_post_mem_req",   bus1.mem_req,   1'b1);
                check("t5_post_mem_addr",  bus1.mem_addr,  32'h40);
            end
            if (c == 1) check("t5_second_addr", bus1.mem_addr, 32'h41);
            next();
        end
        check("t5_pop_count", pops[1] - base, 10 - LAT);

        // PC wrap from 0xFFFF_FFFC to 0x0
        bus2.out_ready = 1'b1;
        push_stream(2, 32'hFFFF_FFFC, 40);
        base = pops[2];
        rst2 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) check("t6_top_addr",  bus2.mem_addr, 32'h1FF);
            if (c == 1) check("t6_wrap_addr", bus2.mem_addr, 32'h0);
            next();
        end
        check("t6_pop_count", pops[2] - base, 8 - LAT);

        repeat (2) next();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
